apb_fifo_slave: RTL
===================

# apb_fifo_slave

APB responder peripheral holding a DEPTH-entry 32-bit FIFO behind four memory-mapped registers, with programmable wait-state insertion on PREADY. It occupies one slave slot of the system APB bus, such as 0x1000_2xxx, and receives that slot's PSELx, the shared PADDR/PWRITE/PENABLE/PWDATA, and returns PRDATA/PREADY into the master's read mux. Software pushes words through one register and pops them through another. Status reports fill level and sticky error flags.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..256
- WAIT_CYCLES, 1, wait states inserted in ACCESS before PREADY asserts; 0 = zero-wait
- PCLK  input  1  bus clock; all logic on rising edge
- PRESET  input  1  reset, synchronous, active-high
- PADDR  input  4  local byte offset; PADDR[3:2] selects register, PADDR[1:0] ignored
- PWRITE  input  1  1 = write, 0 = read
- PENABLE  input  1  APB access-phase indicator
- PWDATA  input  32  write data
- PSEL  input  1  slot select from the bus decoder
- PRDATA  output  32  read data; valid only while PREADY=1, else 0
- PREADY  output  1  transfer-complete handshake

## Operation
- Register map:
  - 0x0 CTRL (W): bit0 = 1 flushes the FIFO. Count goes to 0, pointers go to 0, sticky flags are unchanged. Reads return 0.
  - 0x4 STATUS (R/W1C): [0] empty, [1] full, [2] overflow sticky, [3] underflow sticky, [15:8] count, others 0. Writing 1 to bit2 or bit3 clears that flag.
  - 0x8 WDATA (W): a write pushes PWDATA. Reads return 0.
  - 0xC RDATA (R): a read pops the head word, returned on PRDATA. Writes are ignored.
- FSM states IDLE and ACCESS, plus wait counter cnt with width $clog2(WAIT_CYCLES+1), minimum 1 bit.
  - IDLE: if PSEL=1 and PENABLE=0 (setup phase), load cnt=WAIT_CYCLES and go to ACCESS. Otherwise stay.
  - ACCESS, PSEL=0: abort. Go to IDLE with no side effect.
  - ACCESS, PSEL=1, PENABLE=1, cnt≠0: decrement cnt, PREADY=0.
  - ACCESS, PSEL=1, PENABLE=1, cnt=0: PREADY=1 (combinational from state and cnt), PRDATA is driven, the side effect commits at this clock edge, next state is IDLE.
- Side effects occur exactly once per transfer, only in the PREADY=1 cycle.
- Push when full: data is dropped, pointers hold, overflow is set.
- Pop when empty: PRDATA=0, pointers hold, underflow is set.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits and ranges 0..DEPTH.
- STATUS read returns the pre-transaction value.
- A flush and a sticky-flag set cannot coincide, because there is one transfer per access.

## Timing
- Reset state (synchronous, takes effect at the first PCLK edge with PRESET=1):
  - state=IDLE, cnt=0, PREADY=0, PRDATA=0
  - FIFO empty, pointers 0, sticky flags 0; storage contents are don't-care
- Reset during ACCESS aborts the transfer with no commit. PREADY is 0 from the next cycle.
- Latency with a standard master (1 setup cycle followed by access): PREADY rises in access cycle WAIT_CYCLES+1.
  - Total transfer is WAIT_CYCLES+2 cycles.
  - With WAIT_CYCLES=0: setup, then PREADY=1 in the first access cycle.
- PREADY is high for exactly one cycle per transfer and is never high in IDLE.
- Back-to-back transfers: a new setup phase in the cycle immediately after PREADY is accepted (IDLE sees PSEL=1, PENABLE=0).
- Status reflects a push or pop from the cycle after the commit edge.
- PRDATA is the combinational FIFO head during the pop's PREADY cycle, and 0 otherwise.

## Test plan
- Reset then STATUS read, WAIT_CYCLES=1 → PREADY low for 1 access cycle, then high once; PRDATA=0x0000_0001 (empty, count 0).
- Push 0xA5A5_0001..0xA5A5_0008 via 0x8, then read STATUS → 0x0000_0802. Ninth push of 0xDEAD_BEEF → STATUS=0x0000_0806, and the next 8 pops return 0xA5A5_0001..0xA5A5_0008 in order.
- Pop from empty → PRDATA=0, STATUS=0x0000_0009. Write 0x8 to STATUS → STATUS=0x0000_0001.
- Wrap-around: push 5, pop 5, push 8, pop 8 → data returned in order, final STATUS=0x0000_0001.
- Abort: deassert PSEL during a wait state on a WDATA write of 0x1234_5678 → no PREADY, count unchanged. Assert PRESET mid-ACCESS → PREADY=0, STATUS=0x0000_0001 afterward.
- Flush: push 3 with overflow previously set, write 0x1 to CTRL → STATUS=0x0000_0005. With WAIT_CYCLES=0, back-to-back writes each complete in 2 cycles.

Source files
------------

// File: rtl/apb_fifo_slave.sv
// APB responder fronting a DEPTH x 32-bit FIFO through four registers
// (CTRL, STATUS, WDATA, RDATA), with WAIT_CYCLES wait states before PREADY.
module apb_fifo_slave #(
  parameter int DEPTH       = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_WDATA  = 2'd2,
    REG_RDATA  = 2'd3
  } reg_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          ovf, udf;
  logic          empty, full;
  logic [31:0]   status;
  reg_t          reg_sel;
  logic          commit, do_push, do_pop;
  logic          unused;

  assign unused  = ^PADDR[1:0];
  assign reg_sel = reg_t'(PADDR[3:2]);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign status  = {16'h0000, 8'(count), 4'h0, udf, ovf, full, empty};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // PREADY also requires PSEL/PENABLE so an aborted access never completes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    PREADY     = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_next = ACCESS;
          cnt_next   = CW'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_next = IDLE;
        end else if (PENABLE) begin
          if (cnt != '0) begin
            cnt_next = cnt - CW'(1);
          end else begin
            PREADY     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign commit  = PREADY && !PRESET;
  assign do_push = commit && PWRITE && (reg_sel == REG_WDATA) && !full;
  assign do_pop  = commit && !PWRITE && (reg_sel == REG_RDATA) && !empty;

  always_comb begin
    PRDATA = '0;
    if (PREADY && !PWRITE) begin
      case (reg_sel)
        REG_STATUS: PRDATA = status;
        REG_RDATA:  PRDATA = empty ? '0 : mem[rd_ptr];
        default:    PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= PWDATA;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (commit) begin
      case (reg_sel)
        REG_CTRL: begin
          if (PWRITE && PWDATA[0]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end
        end
        REG_STATUS: begin
          if (PWRITE) begin
            if (PWDATA[2]) ovf <= 1'b0;
            if (PWDATA[3]) udf <= 1'b0;
          end
        end
        REG_WDATA: begin
          if (PWRITE) begin
            if (full) begin
              ovf <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
              count  <= count + (AW+1)'(1);
            end
          end
        end
        REG_RDATA: begin
          if (!PWRITE) begin
            if (empty) begin
              udf <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
              count  <= count - (AW+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
